// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory latency model:
//   state_t      - controller states (CLEAR, IDLE, WAIT, RESP)
//   CNT_W        - width of the latency down-counter
//   lanes()      - number of byte lanes in a data word
//   align_shift()- shift that turns a byte offset into a word index
package dmem_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      WAIT,
      RESP
   } state_t;

   function automatic int lanes(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int align_shift(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge
// Purely combinational byte-lane merge: every lane whose enable is set takes
// the new write data, every other lane keeps the old stored value.
// Ports:
//   old_word  in  DATA_W    word currently held in memory
//   wdata     in  DATA_W    lane-aligned write data
//   byteen    in  DATA_W/8  per-lane write enables
//   merged    out DATA_W    resulting word
module dmem_byte_merge #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   old_word,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] byteen,
   output logic [DATA_W-1:0]   merged
);

   // Start from the old word and overwrite only the enabled lanes, so an
   // all-zero enable mask simply passes the stored word through (a read).
   always_comb begin
      merged = old_word;
      for (int k = 0; k < DATA_W / 8; k++) begin
         if (byteen[k]) begin
            merged[8*k +: 8] = wdata[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_latency_model.sv
// dmem_latency_model
// Data-memory model with a fixed access latency behind a valid/ready
// handshake, byte-lane writes, out-of-range detection and a trace port that
// reports every committed write.
// Optional feature macro: DMEM_CLEAR_EN - when defined, the memory is zeroed
// one word per cycle after reset before the first request is accepted.
// Ports:
//   clk, reset (synchronous, active-low)
//   req_valid/req_ready     request handshake
//   req_addr/req_wdata/req_byteen/req_pc  request payload (byteen 0 = read)
//   rsp_valid/rsp_rdata/rsp_err           one-cycle response
//   trc_valid/trc_pc/trc_addr/trc_data    committed-write trace pulse
module dmem_latency_model #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                DEPTH_WORDS = 4096,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                LAT         = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_byteen,
   input  logic [31:0]         req_pc,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                trc_valid,
   output logic [31:0]         trc_pc,
   output logic [ADDR_W-1:0]   trc_addr,
   output logic [DATA_W-1:0]   trc_data
);

   import dmem_pkg::*;

   localparam int SHIFT = align_shift(DATA_W);
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   mem [DEPTH_WORDS];
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_err_q;

   logic                accept;
   logic [ADDR_W-1:0]   offset;
   logic [ADDR_W-1:0]   word_off;
   logic [IDX_W-1:0]    word_idx;
   logic                in_range;
   logic                is_write;
   logic [DATA_W-1:0]   merged_word;
   logic                mem_we;
   logic [IDX_W-1:0]    mem_idx;
   logic [DATA_W-1:0]   mem_wdata;

`ifdef DMEM_CLEAR_EN
   logic [IDX_W-1:0]    clr_idx;
`endif

   assign req_ready = (state == IDLE) || (state == RESP);
   assign accept    = req_valid && req_ready;

   // The subtraction wraps for addresses below the base, so the explicit
   // lower-bound compare is what rejects them.
   assign offset   = req_addr - BASE_ADDR;
   assign word_off = offset >> SHIFT;
   assign word_idx = word_off[IDX_W-1:0];
   assign in_range = (req_addr >= BASE_ADDR) && (word_off < ADDR_W'(DEPTH_WORDS));
   assign is_write = |req_byteen;

   // Response outputs are only driven while the response pulse is present,
   // so the bench never sees stale data between transactions.
   assign rsp_valid = (state == RESP);
   assign rsp_rdata = rsp_valid ? rsp_data_q : '0;
   assign rsp_err   = rsp_valid && rsp_err_q;

   dmem_byte_merge #(
      .DATA_W (DATA_W)
   ) u_merge (
      .old_word (mem[word_idx]),
      .wdata    (req_wdata),
      .byteen   (req_byteen),
      .merged   (merged_word)
   );

   // Single memory write port shared by the clear sweep and request writes.
   // Requests cannot be accepted during CLEAR, so the two never collide; the
   // clear assignment comes last only to make that priority obvious.
   always_comb begin
      mem_we    = 1'b0;
      mem_idx   = word_idx;
      mem_wdata = merged_word;
      if (reset) begin
         if (accept && in_range && is_write) begin
            mem_we = 1'b1;
         end
`ifdef DMEM_CLEAR_EN
         if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_idx   = clr_idx;
            mem_wdata = '0;
         end
`endif
      end
   end

   // Storage array carries no reset: without the clear feature its contents
   // deliberately survive a reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wdata;
      end
   end

   // Controller: on acceptance the response word (merged for writes, stored
   // word for reads, zero when out of range) is latched immediately, and the
   // counter then only has to time when it is presented. Acceptance in RESP
   // takes priority over returning to IDLE, which is what gives full
   // throughput at LAT=1.
   always_ff @(posedge clk) begin
      if (!reset) begin
`ifdef DMEM_CLEAR_EN
         state   <= CLEAR;
         clr_idx <= '0;
`else
         state   <= IDLE;
`endif
         cnt        <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         trc_valid  <= 1'b0;
         trc_pc     <= '0;
         trc_addr   <= '0;
         trc_data   <= '0;
      end else begin
         trc_valid <= 1'b0;
         if (accept) begin
            if (LAT == 1) begin
               state <= RESP;
            end else begin
               state <= WAIT;
               cnt   <= CNT_W'(LAT - 2);
            end
            rsp_data_q <= in_range ? merged_word : '0;
            rsp_err_q  <= !in_range;
            if (in_range && is_write) begin
               trc_valid <= 1'b1;
               trc_pc    <= req_pc;
               trc_addr  <= req_addr & ~ADDR_W'((1 << SHIFT) - 1);
               trc_data  <= merged_word;
            end
         end else begin
            unique case (state)
               CLEAR: begin
`ifdef DMEM_CLEAR_EN
                  clr_idx <= clr_idx + 1'b1;
                  if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                     state <= IDLE;
                  end
`else
                  state <= IDLE;
`endif
               end
               IDLE: begin
                  state <= IDLE;
               end
               WAIT: begin
                  if (cnt == '0) begin
                     state <= RESP;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               RESP: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmem_latency_model.sv
// tb_dmem_latency_model
// Directed bench for dmem_latency_model (DEPTH_WORDS=16, BASE_ADDR=0, LAT=2)
// with a second LAT=1 instance for the back-to-back stream. Expected
// responses come from a small memory model and are queued at acceptance,
// then popped when rsp_valid is seen. Works with or without DMEM_CLEAR_EN:
// without it, the memory is preloaded with zeros through the request port.
module tb_dmem_latency_model;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_valid1;
   logic [31:0] req_addr, req_wdata, req_pc;
   logic [3:0]  req_byteen;

   logic        req_ready, rsp_valid, rsp_err, trc_valid;
   logic [31:0] rsp_rdata, trc_pc, trc_addr, trc_data;
   logic        req_ready1, rsp_valid1, rsp_err1, trc_valid1;
   logic [31:0] rsp_rdata1, trc_pc1, trc_addr1, trc_data1;

   exp_t        sb[$];
   logic [31:0] model_mem [16];
   int          checks = 0;
   int          passes = 0;

   always #5 clk = ~clk;

   dmem_latency_model #(
      .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LAT(2)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_addr(trc_addr), .trc_data(trc_data)
   );

   dmem_latency_model #(
      .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LAT(1)
   ) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid1), .req_ready(req_ready1),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen), .req_pc(req_pc),
      .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
      .trc_valid(trc_valid1), .trc_pc(trc_pc1), .trc_addr(trc_addr1), .trc_data(trc_data1)
   );

   // One comparison: counts it, and reports tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Model of one accepted request: merges enabled lanes, commits writes and
   // queues the response the DUT should eventually present.
   task automatic modelPush(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      exp_t        e;
      logic [31:0] w;
      if (a < 32'h40) begin
         w = model_mem[a[5:2]];
         for (int k = 0; k < 4; k++) begin
            if (be[k]) w[8*k +: 8] = d[8*k +: 8];
         end
         if (be != 4'b0) model_mem[a[5:2]] = w;
         e.rdata = w;
         e.err   = 1'b0;
      end else begin
         e.rdata = 32'h0;
         e.err   = 1'b1;
      end
      sb.push_back(e);
   endtask

   // Issues one request on the LAT=2 instance. Called at a falling edge;
   // returns at the falling edge just after the accepting rising edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [31:0] pc);
      int waited = 0;
      req_addr   = a;
      req_wdata  = d;
      req_byteen = be;
      req_pc     = pc;
      req_valid  = 1'b1;
      while (req_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (req_ready !== 1'b1) checkOutput("req_ready_timeout", req_ready, 32'h1);
      @(posedge clk);
      modelPush(a, d, be);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drainScoreboard();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      checkOutput("sb_drain", sb.size(), 32'h0);
   endtask

   // Response monitor for the LAT=2 instance.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("rsp_unexpected", rsp_valid, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("rsp_rdata", rsp_rdata, e.rdata);
            checkOutput("rsp_err", rsp_err, 32'(e.err));
         end
      end
   end

   initial begin
      logic [31:0] stream [6];
      stream[0] = 32'h0;  stream[1] = 32'h8;  stream[2] = 32'hC;
      stream[3] = 32'h3C; stream[4] = 32'h4;  stream[5] = 32'h10;
      for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;

      reset = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0;
      req_addr = '0; req_wdata = '0; req_byteen = '0; req_pc = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_rsp_valid", rsp_valid, 32'h0);
      checkOutput("reset_trc_valid", trc_valid, 32'h0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
      reset = 1'b1;

`ifdef DMEM_CLEAR_EN
      for (int i = 0; i < 16; i++) begin
         checkOutput("clear_ready_low", req_ready, 32'h0);
         @(negedge clk);
      end
      checkOutput("clear_ready_rise", req_ready, 32'h1);
`else
      checkOutput("reset_ready", req_ready, 32'h1);
      for (int i = 0; i < 16; i++) applyStimulus(32'(i * 4), 32'h0, 4'hF, 32'h0);
      drainScoreboard();
`endif

      // Read of the last word after clear/preload.
      applyStimulus(32'h3C, 32'h0, 4'h0, 32'h0);
      drainScoreboard();

      // Full-word write: trace pulse right after acceptance, response 2 later.
      applyStimulus(32'h8, 32'h11223344, 4'hF, 32'h0040_0100);
      checkOutput("wr_trc_valid", trc_valid, 32'h1);
      checkOutput("wr_trc_addr", trc_addr, 32'h8);
      checkOutput("wr_trc_data", trc_data, 32'h11223344);
      checkOutput("wr_trc_pc", trc_pc, 32'h0040_0100);
      checkOutput("wr_wait_rsp_valid", rsp_valid, 32'h0);
      checkOutput("wr_wait_rdata_zero", rsp_rdata, 32'h0);
      @(negedge clk);
      checkOutput("wr_rsp_valid", rsp_valid, 32'h1);
      checkOutput("wr_trc_pulse_end", trc_valid, 32'h0);

      // Partial write accepted in the RESP cycle, then unaligned read.
      applyStimulus(32'h9, 32'h0000AB00, 4'b0010, 32'h0040_0104);
      checkOutput("pw_trc_addr", trc_addr, 32'h8);
      checkOutput("pw_trc_data", trc_data, 32'h1122AB44);
      applyStimulus(32'hA, 32'h0, 4'h0, 32'h0);
      drainScoreboard();

      // Out-of-range write: error response, no trace, memory untouched.
      applyStimulus(32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0040_0108);
      checkOutput("oor_no_trace", trc_valid, 32'h0);
      @(negedge clk);
      checkOutput("oor_rsp_err", rsp_err, 32'h1);
      applyStimulus(32'h0, 32'h0, 4'h0, 32'h0);
      drainScoreboard();

      // Back-to-back reads with req_valid held high at LAT=2.
      req_valid = 1'b1; req_byteen = 4'h0;
      for (int c = 0; c < 12; c++) begin
         checkOutput("b2b_ready", req_ready, 32'((c % 2) == 0));
         checkOutput("b2b_rsp_valid", rsp_valid, 32'(c >= 2 && (c % 2) == 0));
         if ((c % 2) == 0) req_addr = stream[c / 2];
         @(posedge clk);
         if ((c % 2) == 0) modelPush(stream[c / 2], 32'h0, 4'h0);
         @(negedge clk);
         if (c == 10) req_valid = 1'b0;
      end
      checkOutput("b2b_last_rsp", rsp_valid, 32'h1);
      @(negedge clk);
      checkOutput("b2b_idle_ready", req_ready, 32'h1);
      drainScoreboard();

      // Same stream at LAT=1: a response every cycle.
      for (int c = 0; c < 8; c++) begin
         checkOutput("lat1_ready", req_ready1, 32'h1);
         checkOutput("lat1_rsp_valid", rsp_valid1, 32'(c >= 1 && c <= 6));
         if (rsp_valid1 === 1'b1) checkOutput("lat1_rsp_err", rsp_err1, 32'h0);
         req_valid1 = (c < 6);
         req_addr   = stream[c % 6];
         @(negedge clk);
      end

      // Reset during the WAIT of a write drops the response.
      applyStimulus(32'h14, 32'hDEADBEEF, 4'hF, 32'h0040_0200);
      checkOutput("rst_trc_valid", trc_valid, 32'h1);
      reset = 1'b0;
      sb.delete();
`ifdef DMEM_CLEAR_EN
      for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("rst_no_rsp", rsp_valid, 32'h0);
      end
      reset = 1'b1;
      applyStimulus(32'h14, 32'h0, 4'h0, 32'h0);
      drainScoreboard();

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
